// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of one sdram_controller: port 0 fixed priority, ports 1/2 round-robin.
// Optional starvation promotion for ports 1/2 is enabled by defining SDRAM_ARB_STARVE_EN.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int BURST_W = 10
`ifdef SDRAM_ARB_STARVE_EN
    , parameter int STARVE_LIMIT = 64
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sdram_init_done,
    input  logic [2:0]           p_req,
    input  logic [2:0]           p_we,
    input  logic [3*ADDR_W-1:0]  p_addr,
    input  logic [3*BURST_W-1:0] p_burst,
    input  logic [47:0]          p_wdata,
    input  logic [5:0]           p_wmask,
    output logic [2:0]           p_ack,
    output logic [2:0]           p_wr_take,
    output logic [2:0]           p_rd_valid,
    output logic [15:0]          rd_data,
    output logic [ADDR_W-1:0]    sdram_rw_addr,
    output logic                 sdram_rd_req,
    output logic [BURST_W-1:0]   sdram_rd_burst,
    input  logic                 sdram_rd_ack,
    input  logic [15:0]          sdram_dout,
    output logic                 sdram_wr_req,
    output logic [BURST_W-1:0]   sdram_wr_burst,
    input  logic                 sdram_wr_ack,
    output logic [15:0]          sdram_din,
    output logic [1:0]           sdram_mask
);
    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d, rr_last_q, rr_last_d;
    logic [ADDR_W-1:0]    cmd_addr_q, cmd_addr_d, rw_addr_q, rw_addr_d;
    logic                 cmd_we_q, cmd_we_d;
    logic [BURST_W-1:0]   cmd_burst_q, cmd_burst_d, beat_q, beat_d, burst_out_q, burst_out_d;
    logic [15:0]          rd_data_q, rd_data_d;
    logic [2:0]           rd_valid_q, rd_valid_d, ack_q, ack_d;
    logic                 rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic [1:0]           rr_pick, win;
    logic [2:1]           starved;
    logic                 grant_now, wr_phase, beat_ack;

    assign grant_now = (state_q == IDLE) && sdram_init_done && (|p_req);

`ifdef SDRAM_ARB_STARVE_EN
    localparam logic [7:0] STARVE_TH = (STARVE_LIMIT > 255) ? 8'd255 : 8'(STARVE_LIMIT);
    logic [2:1][7:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starved = '0;
        for (int i = 1; i <= 2; i++)
            starved[i] = p_req[i] && (starve_cnt_q[i] >= STARVE_TH);
    end

    // A port being served (ISSUE..DONE) is not waiting, so its counter stands still.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        for (int i = 1; i <= 2; i++) begin
            if (grant_now && win == 2'(i))
                starve_cnt_d[i] = '0;
            else if (p_req[i] && !(state_q != IDLE && gnt_q == 2'(i)) && starve_cnt_q[i] != 8'hff)
                starve_cnt_d[i] = starve_cnt_q[i] + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_cnt_q <= '0;
        else          starve_cnt_q <= starve_cnt_d;
    end
`else
    assign starved = '0;
`endif

    always_comb begin
        if (p_req[1] && p_req[2]) rr_pick = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
        else                      rr_pick = p_req[1] ? 2'd1 : 2'd2;
        if (starved == 2'b11)     win = rr_pick;
        else if (starved[1])      win = 2'd1;
        else if (starved[2])      win = 2'd2;
        else if (p_req[0])        win = 2'd0;
        else                      win = rr_pick;
    end

    assign wr_phase  = (state_q == BURST) && cmd_we_q;
    assign beat_ack  = cmd_we_q ? sdram_wr_ack : sdram_rd_ack;
    assign sdram_din  = wr_phase ? p_wdata[int'(gnt_q)*16 +: 16] : 16'h0;
    assign sdram_mask = wr_phase ? p_wmask[int'(gnt_q)*2 +: 2] : 2'b00;
    assign p_wr_take  = (wr_phase && sdram_wr_ack) ? (3'b001 << gnt_q) : 3'b000;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_last_d   = rr_last_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_we_d    = cmd_we_q;
        cmd_burst_d = cmd_burst_q;
        beat_d      = beat_q;
        burst_out_d = burst_out_q;
        rw_addr_d   = rw_addr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 3'b000;
        ack_d       = ack_q;
        rd_req_d    = rd_req_q;
        wr_req_d    = wr_req_q;
        case (state_q)
            IDLE: if (grant_now) begin
                gnt_d       = win;
                cmd_addr_d  = p_addr[int'(win)*ADDR_W +: ADDR_W];
                cmd_we_d    = p_we[win];
                cmd_burst_d = p_burst[int'(win)*BURST_W +: BURST_W];
                if (cmd_burst_d == '0) begin
                    state_d = DONE;
                    ack_d   = 3'b001 << win;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rw_addr_d   = cmd_addr_q;
                burst_out_d = cmd_burst_q;
                rd_req_d    = !cmd_we_q;
                wr_req_d    = cmd_we_q;
                beat_d      = '0;
                state_d     = BURST;
            end
            BURST: if (beat_ack) begin
                beat_d = beat_q + 1'b1;
                if (!cmd_we_q) begin
                    rd_data_d  = sdram_dout;
                    rd_valid_d = 3'b001 << gnt_q;
                end
                if (beat_q == cmd_burst_q - 1'b1) begin
                    rd_req_d = 1'b0;
                    wr_req_d = 1'b0;
                    ack_d    = 3'b001 << gnt_q;
                    state_d  = DONE;
                end
            end
            DONE: if (!p_req[gnt_q]) begin
                ack_d   = 3'b000;
                state_d = IDLE;
                if (gnt_q != 2'd0) rr_last_d = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_last_q   <= 2'd2;
            cmd_addr_q  <= '0;
            cmd_we_q    <= 1'b0;
            cmd_burst_q <= '0;
            beat_q      <= '0;
            burst_out_q <= '0;
            rw_addr_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= '0;
            ack_q       <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_last_q   <= rr_last_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_we_q    <= cmd_we_d;
            cmd_burst_q <= cmd_burst_d;
            beat_q      <= beat_d;
            burst_out_q <= burst_out_d;
            rw_addr_q   <= rw_addr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            ack_q       <= ack_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
        end
    end

    assign p_ack          = ack_q;
    assign p_rd_valid     = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign sdram_rw_addr  = rw_addr_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_burst = burst_out_q;
    assign sdram_wr_burst = burst_out_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scenario bench for sdram_port_arbiter: bench-side controller model feeds beats, scoreboard queues hold expected read/write data.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 24;
    localparam int BURST_W = 10;
    localparam logic [23:0] A0 = 24'h001200, A0B = 24'h003400, A1 = 24'h000100, A2 = 24'h000200;

    logic clk = 0, reset_n = 0, sdram_init_done = 0;
    logic [2:0] p_req = 0, p_we = 0;
    logic [3*ADDR_W-1:0] p_addr = 0;
    logic [3*BURST_W-1:0] p_burst = 0;
    logic [47:0] p_wdata = 0;
    logic [5:0] p_wmask = 0;
    logic [2:0] p_ack, p_wr_take, p_rd_valid;
    logic [15:0] rd_data, sdram_din, sdram_dout = 0;
    logic [ADDR_W-1:0] sdram_rw_addr;
    logic sdram_rd_req, sdram_wr_req, sdram_rd_ack = 0, sdram_wr_ack = 0;
    logic [BURST_W-1:0] sdram_rd_burst, sdram_wr_burst;
    logic [1:0] sdram_mask;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .reset_n(reset_n), .sdram_init_done(sdram_init_done),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_burst(p_burst),
        .p_wdata(p_wdata), .p_wmask(p_wmask), .p_ack(p_ack), .p_wr_take(p_wr_take),
        .p_rd_valid(p_rd_valid), .rd_data(rd_data), .sdram_rw_addr(sdram_rw_addr),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_burst(sdram_rd_burst), .sdram_rd_ack(sdram_rd_ack),
        .sdram_dout(sdram_dout), .sdram_wr_req(sdram_wr_req), .sdram_wr_burst(sdram_wr_burst),
        .sdram_wr_ack(sdram_wr_ack), .sdram_din(sdram_din), .sdram_mask(sdram_mask));

    always #5 clk = ~clk;

    wire [88:0] all_outs = {p_ack, p_wr_take, p_rd_valid, rd_data, sdram_rw_addr, sdram_rd_req,
                            sdram_rd_burst, sdram_wr_req, sdram_wr_burst, sdram_din, sdram_mask};

    typedef struct packed { logic [1:0] port; logic [15:0] data; } rd_exp_t;
    typedef struct packed { logic [15:0] d; logic [1:0] m; } wr_exp_t;
    rd_exp_t exp_q[$];
    wr_exp_t wr_q[$];
    int total = 0, bad = 0;
    int ctl_left = 0, ctl_beat = 0;
    bit ctl_busy = 0;

    function automatic logic [1:0] port_of(input logic [23:0] a);
        if (a == A1) return 2'd1;
        if (a == A2) return 2'd2;
        return 2'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Controller model: once a request is seen, one ack per cycle until the burst is exhausted.
    task automatic ctl_step();
        rd_exp_t e;
        sdram_rd_ack = 0;
        sdram_wr_ack = 0;
        if (!sdram_rd_req && !sdram_wr_req) begin
            ctl_busy = 0;
        end else begin
            if (!ctl_busy) begin
                ctl_busy = 1;
                ctl_beat = 0;
                ctl_left = sdram_rd_req ? int'(sdram_rd_burst) : int'(sdram_wr_burst);
            end
            if (ctl_left > 0) begin
                ctl_left--;
                if (sdram_rd_req) begin
                    sdram_rd_ack = 1;
                    sdram_dout = 16'(ctl_beat);
                    e.port = port_of(sdram_rw_addr);
                    e.data = 16'(ctl_beat);
                    exp_q.push_back(e);
                end else begin
                    sdram_wr_ack = 1;
                end
                ctl_beat++;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        p_req = 0;
        sdram_rd_ack = 0;
        sdram_wr_ack = 0;
        ctl_busy = 0;
        ctl_left = 0;
        cyc();
        cyc();
        exp_q.delete();
        wr_q.delete();
        reset_n = 1;
        cyc();
    endtask

    task automatic release_port(input int p, output bit ok);
        p_req[p] = 0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!p_ack[p]) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit got, ok;
        rd_exp_t e;
        reset_n = 0;
        cyc();
        cyc();
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_outs); end
        reset_n = 1;
        p_we = 3'b000;
        p_addr = {A2, A1, A0};
        p_burst = {10'd1, 10'd1, 10'd1};
        p_req = 3'b111;
        for (int i = 0; i < 20; i++) begin
            cyc();
            total++;
            if (sdram_rd_req || sdram_wr_req || p_ack !== 3'b000) begin
                bad++;
                $display("FAIL init_gate cyc=%0d rd=%b wr=%b ack=%b want 0/0/000", i, sdram_rd_req, sdram_wr_req, p_ack);
            end
        end
        sdram_init_done = 1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (sdram_rd_req || sdram_wr_req) begin got = 1; break; end
        end
        total++;
        if (!got || !sdram_rd_req || sdram_rw_addr !== A0) begin
            bad++;
            $display("FAIL first_grant seen=%b rd=%b addr=%h want 1/1/%h", got, sdram_rd_req, sdram_rw_addr, A0);
        end
        p_req[2:1] = 2'b00;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (p_rd_valid !== 3'b000) begin
                total++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (p_rd_valid !== (3'b001 << e.port) || rd_data !== e.data) begin
                    bad++;
                    $display("FAIL p0_beat got v=%b d=%h want v=%b d=%h", p_rd_valid, rd_data, 3'b001 << e.port, e.data);
                end
            end
            if (p_ack[0]) break;
            ctl_step();
        end
        total++;
        if (p_ack !== 3'b001) begin bad++; $display("FAIL p0_ack got=%b want=001", p_ack); end
        release_port(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL p0_release ack=%b want=000", p_ack); end
    endtask

    task automatic test_read256();
        rd_exp_t e;
        int nv = 0;
        bit first = 1, last_given = 0, last_chk = 0, acked = 0, ok;
        p_we = 3'b000;
        p_addr[0 +: ADDR_W] = A0;
        p_burst[0 +: BURST_W] = 10'd256;
        p_req = 3'b001;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (p_rd_valid !== 3'b000) begin
                total++;
                nv++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (p_rd_valid !== (3'b001 << e.port) || rd_data !== e.data) begin
                    bad++;
                    $display("FAIL rd256_beat got v=%b d=%h want v=%b d=%h", p_rd_valid, rd_data, 3'b001 << e.port, e.data);
                end
            end
            if (last_given && !last_chk) begin
                last_chk = 1;
                total++;
                if (sdram_rd_req !== 1'b0) begin bad++; $display("FAIL rd_req_drop got=%b want=0", sdram_rd_req); end
            end
            if (p_ack[0]) begin acked = 1; break; end
            if (first && sdram_rd_req) begin
                first = 0;
                total++;
                if (sdram_rw_addr !== A0 || sdram_rd_burst !== 10'd256 || sdram_wr_req) begin
                    bad++;
                    $display("FAIL rd256_cmd addr=%h burst=%0d wr=%b want %h/256/0", sdram_rw_addr, sdram_rd_burst, sdram_wr_req, A0);
                end
            end
            ctl_step();
            if (sdram_rd_ack && ctl_left == 0) last_given = 1;
        end
        total++;
        if (!acked || nv != 256 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd256_done ack=%b beats=%0d left=%0d want 1/256/0", acked, nv, exp_q.size());
        end
        release_port(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd256_release ack=%b want=000", p_ack); end
    endtask

    task automatic test_write();
        logic [15:0] words [2];
        wr_exp_t e;
        wr_exp_t x;
        int w = 0, takes = 0;
        bit took = 0, saw_rd = 0, first = 1, acked = 0, ok;
        words[0] = 16'hAAAA;
        words[1] = 16'h5555;
        for (int i = 0; i < 2; i++) begin x.d = words[i]; x.m = 2'b01; wr_q.push_back(x); end
        p_we = 3'b010;
        p_addr[ADDR_W +: ADDR_W] = A1;
        p_burst[BURST_W +: BURST_W] = 10'd2;
        p_wdata[31:16] = words[0];
        p_wmask[3:2] = 2'b01;
        p_req = 3'b010;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (took) begin
                took = 0;
                w++;
                if (w < 2) p_wdata[31:16] = words[w];
            end
            if (sdram_rd_req) saw_rd = 1;
            if (p_ack[1]) begin acked = 1; break; end
            if (first && sdram_wr_req) begin
                first = 0;
                total++;
                if (sdram_rw_addr !== A1 || sdram_wr_burst !== 10'd2) begin
                    bad++;
                    $display("FAIL wr_cmd addr=%h burst=%0d want %h/2", sdram_rw_addr, sdram_wr_burst, A1);
                end
            end
            ctl_step();
            #1;
            if (p_wr_take !== 3'b000) begin
                total++;
                takes++;
                took = p_wr_take[1];
                e = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
                if (p_wr_take !== 3'b010 || sdram_din !== e.d || sdram_mask !== e.m) begin
                    bad++;
                    $display("FAIL wr_beat take=%b din=%h mask=%b want 010/%h/%b", p_wr_take, sdram_din, sdram_mask, e.d, e.m);
                end
            end
        end
        total++;
        if (!acked || takes != 2 || saw_rd) begin
            bad++;
            $display("FAIL wr_done ack=%b takes=%0d saw_rd=%b want 1/2/0", acked, takes, saw_rd);
        end
        release_port(1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wr_release ack=%b want=000", p_ack); end
    endtask

    task automatic test_round_robin();
        int exp_gnt[$];
        int acks = 0, g;
        rd_exp_t e;
        do_reset();
        sdram_init_done = 1;
        exp_gnt = '{1, 2, 1, 2};
        p_we = 3'b000;
        p_addr = {A2, A1, A0};
        p_burst = {10'd2, 10'd2, 10'd0};
        p_req = 3'b110;
        for (int i = 0; i < 400 && acks < 4; i++) begin
            cyc();
            if (p_rd_valid !== 3'b000) begin
                total++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (p_rd_valid !== (3'b001 << e.port) || rd_data !== e.data) begin
                    bad++;
                    $display("FAIL rr_beat got v=%b d=%h want v=%b d=%h", p_rd_valid, rd_data, 3'b001 << e.port, e.data);
                end
            end
            for (int p = 1; p <= 2; p++) begin
                if (p_ack[p] && p_req[p]) begin
                    total++;
                    g = exp_gnt.pop_front();
                    if (p != g) begin bad++; $display("FAIL rr_order n=%0d got=%0d want=%0d", acks, p, g); end
                    acks++;
                    p_req[p] = 0;
                end else if (!p_ack[p] && !p_req[p]) begin
                    p_req[p] = 1;
                end
            end
            ctl_step();
        end
        total++;
        if (acks != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", acks); end
    endtask

    task automatic test_burst0();
        bit saw = 0, acked = 0, ok;
        do_reset();
        sdram_init_done = 1;
        p_we = 3'b000;
        p_addr[2*ADDR_W +: ADDR_W] = A2;
        p_burst[2*BURST_W +: BURST_W] = 10'd0;
        p_req = 3'b100;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (sdram_rd_req || sdram_wr_req) saw = 1;
            if (p_ack[2]) begin acked = 1; break; end
        end
        total++;
        if (!acked || saw || p_ack !== 3'b100) begin
            bad++;
            $display("FAIL burst0 ack=%b req_seen=%b want 100/0", p_ack, saw);
        end
        release_port(2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL burst0_release ack=%b want=000", p_ack); end
    endtask

    task automatic test_reset_midburst();
        int nv = 0;
        bit first = 1, acked = 0, ok;
        rd_exp_t e;
        do_reset();
        sdram_init_done = 1;
        p_we = 3'b000;
        p_addr[0 +: ADDR_W] = A0;
        p_burst[0 +: BURST_W] = 10'd8;
        p_req = 3'b001;
        for (int i = 0; i < 60 && nv < 3; i++) begin
            cyc();
            if (p_rd_valid !== 3'b000) nv++;
            if (nv < 3) ctl_step();
        end
        reset_n = 0;
        sdram_rd_ack = 0;
        #1;
        total++;
        if (nv != 3 || all_outs !== '0) begin bad++; $display("FAIL midburst_reset beats=%0d outs=%h want 3/0", nv, all_outs); end
        cyc();
        cyc();
        exp_q.delete();
        ctl_busy = 0;
        ctl_left = 0;
        p_addr[0 +: ADDR_W] = A0B;
        p_burst[0 +: BURST_W] = 10'd2;
        reset_n = 1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (p_rd_valid !== 3'b000) begin
                total++;
                nv++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                if (p_rd_valid !== (3'b001 << e.port) || rd_data !== e.data) begin
                    bad++;
                    $display("FAIL post_reset_beat got v=%b d=%h want v=%b d=%h", p_rd_valid, rd_data, 3'b001 << e.port, e.data);
                end
            end
            if (first && sdram_rd_req) begin
                first = 0;
                total++;
                if (sdram_rw_addr !== A0B || sdram_rd_burst !== 10'd2) begin
                    bad++;
                    $display("FAIL post_reset_cmd addr=%h burst=%0d want %h/2", sdram_rw_addr, sdram_rd_burst, A0B);
                end
            end
            if (p_ack[0]) begin acked = 1; break; end
            ctl_step();
        end
        total++;
        if (!acked || nv != 2) begin bad++; $display("FAIL post_reset_done ack=%b beats=%0d want 1/2", acked, nv); end
        release_port(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL post_reset_release ack=%b want=000", p_ack); end
    endtask

    task automatic test_starvation();
        int n0 = 0, gcyc = -1;
        do_reset();
        sdram_init_done = 1;
        p_we = 3'b000;
        p_addr = {A2, A1, A0};
        p_burst = {10'd1, 10'd0, 10'd4};
        p_req = 3'b101;
        for (int i = 1; i <= 600; i++) begin
            cyc();
            if (gcyc < 0 && sdram_rd_req && sdram_rw_addr == A2) gcyc = i;
            if (p_ack[0] && p_req[0]) begin p_req[0] = 0; n0++; end
            else if (!p_ack[0] && !p_req[0]) p_req[0] = 1;
            if (p_ack[2]) p_req[2] = 0;
`ifdef SDRAM_ARB_STARVE_EN
            if (gcyc >= 0) break;
`else
            if (n0 >= 10) break;
`endif
            ctl_step();
        end
`ifdef SDRAM_ARB_STARVE_EN
        total++;
        if (gcyc < 64 || gcyc > 90) begin bad++; $display("FAIL starve_grant cyc=%0d want 64..90", gcyc); end
`else
        total++;
        if (gcyc >= 0 || n0 < 10) begin bad++; $display("FAIL no_starve p2_cyc=%0d p0_done=%0d want -1/>=10", gcyc, n0); end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_read256();
        test_write();
        test_round_robin();
        test_burst0();
        test_reset_midburst();
        test_starvation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
